spi_host_master: RTL

//  SPI master used by the host/test harness to drive the chip's SPI config slave (SCLK/MOSI/SS/MISO).

---
 rtl/spi_host_master_if.sv | 26 ++
 rtl/spi_host_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_master_if.sv
// Host-side command/data handshake bundle for the SPI host master.
// The master modport is the command source; the slave modport is the SPI engine.
interface spi_host_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_read;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_len;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_len, tx_data, tx_valid,
        input  cmd_ready, tx_ready, rx_data, rx_valid, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_len, tx_data, tx_valid,
        output cmd_ready, tx_ready, rx_data, rx_valid, busy, done
    );
endinterface

// File: rtl/spi_host_master.sv
// SPI mode-0 master: sends {opcode, addr, data...} MSB-first and returns MISO data bytes.
// SCLK half-period is CLK_DIV system clocks; SS is guarded by SS_GUARD half-periods.
module spi_host_master #(
    parameter int CLK_DIV  = 4,
    parameter int SS_GUARD = 2
) (
    input  logic               system_clock,
    input  logic               rst_n,
    spi_host_master_if.slave   host,
    output logic               SCLK,
    output logic               MOSI,
    output logic               SS,
    input  logic               MISO
);

    localparam int CW        = 16;
    localparam int GUARD_CYC = (SS_GUARD * CLK_DIV > 0) ? SS_GUARD * CLK_DIV : 1;
    localparam logic [CW-1:0] HP_LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_LOAD,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    byte_idx_q, byte_idx_d;
    logic          read_q, read_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    tx_sr_q, tx_sr_d;
    logic [7:0]    rx_sr_q, rx_sr_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          ss_q, ss_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          busy_q, busy_d;
    logic          rx_valid_q, rx_valid_d;
    logic          done_q, done_d;

    logic          tx_ready_c;
    logic          load_go;
    logic [7:0]    load_byte;
    logic [7:0]    opcode;
    logic [8:0]    frame_bytes;

    assign opcode      = host.cmd_read ? 8'h03 : 8'h02;
    assign frame_bytes = {1'b0, len_q} + 9'd2;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        byte_idx_d  = byte_idx_q;
        read_d      = read_q;
        addr_d      = addr_q;
        len_d       = len_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rx_data_d   = rx_data_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        ss_d        = ss_q;
        rx_valid_d  = 1'b0;
        done_d      = 1'b0;
        tx_ready_c  = 1'b0;
        load_go     = 1'b0;
        load_byte   = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (host.cmd_valid && cmd_ready_q) begin
                    read_d     = host.cmd_read;
                    addr_d     = host.cmd_addr;
                    len_d      = host.cmd_len;
                    tx_sr_d    = opcode;
                    mosi_d     = opcode[7];
                    rx_sr_d    = 8'h00;
                    ss_d       = 1'b0;
                    cnt_d      = '0;
                    bit_d      = 4'd0;
                    byte_idx_d = 9'd0;
                    state_d    = S_SETUP;
                end else if (cnt_q != '0) begin
                    // SS-high gap after a frame before the next accept
                    cnt_d = cnt_q - CW'(1);
                end
            end

            S_SETUP: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_SHIFT: begin
                if (cnt_q != HP_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        rx_sr_d = {rx_sr_q[6:0], MISO};
                        bit_d   = bit_q + 4'd1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 4'd8) begin
                            // byte boundary: only data bytes are reported upstream
                            byte_idx_d = byte_idx_q + 9'd1;
                            if (byte_idx_q >= 9'd2) begin
                                rx_valid_d = 1'b1;
                                rx_data_d  = rx_sr_q;
                            end
                            state_d = S_LOAD;
                        end else begin
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                            mosi_d  = tx_sr_q[6];
                        end
                    end
                end
            end

            S_LOAD: begin
                if (byte_idx_q == frame_bytes) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else if (byte_idx_q == 9'd1) begin
                    load_go   = 1'b1;
                    load_byte = addr_q;
                end else if (read_q) begin
                    load_go   = 1'b1;
                    load_byte = 8'h00;
                end else if (host.tx_valid && !rx_valid_q) begin
                    // holding off one cycle keeps rx_valid and tx_ready disjoint
                    tx_ready_c = 1'b1;
                    load_go    = 1'b1;
                    load_byte  = host.tx_data;
                end
                if (load_go) begin
                    tx_sr_d = load_byte;
                    mosi_d  = load_byte[7];
                    bit_d   = 4'd0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end

            S_HOLD: begin
                if (cnt_q == GUARD_LAST) begin
                    ss_d    = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = HP_LAST;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready_d = (state_d == S_IDLE) && (cnt_d == '0);
    assign busy_d      = (state_d != S_IDLE);

    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= 4'd0;
            byte_idx_q  <= 9'd0;
            read_q      <= 1'b0;
            addr_q      <= 8'h00;
            len_q       <= 8'h00;
            tx_sr_q     <= 8'h00;
            rx_sr_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ss_q        <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            byte_idx_q  <= byte_idx_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_data_q   <= rx_data_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            ss_q        <= ss_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rx_valid_q  <= rx_valid_d;
            done_q      <= done_d;
        end
    end

    assign SCLK           = sclk_q;
    assign MOSI           = mosi_q;
    assign SS             = ss_q;
    assign host.cmd_ready = cmd_ready_q;
    assign host.busy      = busy_q;
    assign host.done      = done_q;
    assign host.rx_valid  = rx_valid_q;
    assign host.rx_data   = rx_data_q;
    assign host.tx_ready  = tx_ready_c;

endmodule
